// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the SDRAM access bridge.
package sdram_bridge_pkg;

  localparam int WORD_ADDR_W = 26;
  localparam int BYTE_ADDR_W = 28;
  localparam int DATA_W      = 32;
  localparam int WR_ENTRY_W  = WORD_ADDR_W + DATA_W;

  localparam logic [3:0]        BYTE_EN_ALL  = 4'hF;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_RESP
  } bridge_state_t;

  // Avalon addresses bytes; the client addresses 32-bit words.
  function automatic logic [BYTE_ADDR_W-1:0] word_to_byte(input logic [WORD_ADDR_W-1:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Posted-write FIFO holding {word address, write data} entries.
// The head entry is visible combinationally so the bridge can present it
// on Avalon in the same cycle it becomes valid (small depth, LUT storage).
module sdram_wr_fifo
  import sdram_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WR_ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap modulo depth; full is registered from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/sdram_access_bridge.sv
// Bridges single-cycle SDRAM read/write pulses to an Avalon-MM master.
// One outstanding read, posted writes through a small FIFO; a read waits
// until every write queued before it has been issued.
// Optional read watchdog: define SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_access_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int WR_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdram_read_en,
  input  logic                   sdram_write_en,
  input  logic [WORD_ADDR_W-1:0] address_sdram,
  input  logic [DATA_W-1:0]      writeData_sdram,
  output logic [DATA_W-1:0]      data_sdram,
  output logic                   sdram_datareadvalid,
  output logic                   wr_full,
  output logic                   bridge_idle,
  output logic                   protocol_err,
  output logic [BYTE_ADDR_W-1:0] avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [DATA_W-1:0]      avm_writedata,
  output logic [3:0]             avm_byteenable,
  input  logic                   avm_waitrequest,
  input  logic [DATA_W-1:0]      avm_readdata,
  input  logic                   avm_readdatavalid
);

  localparam int CW = $clog2(WR_FIFO_DEPTH) + 1;

  bridge_state_t          state_reg, state_next;
  logic [WORD_ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic                   pending_reg, pending_next;
  logic [CW-1:0]          drain_reg, drain_next;
  logic [DATA_W-1:0]      data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   err_reg, err_next;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          fifo_count_after;
  logic [WR_ENTRY_W-1:0]  fifo_rdata;
  logic                   read_ok;
  logic                   write_cmd;
  logic                   read_cmd;
  logic                   timeout_fire;

  sdram_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH),
    .WIDTH (WR_ENTRY_W)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({address_sdram, writeData_sdram}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_reg;
  logic             in_read;

  assign in_read      = (state_reg == READ_REQ) || (state_reg == READ_RESP);
  assign timeout_fire = in_read && (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting on the current read.
  always_ff @(posedge clk) begin
    if (rst || !in_read || timeout_fire) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + TMO_W'(1);
    end
  end
`else
  // Watchdog absent: a negative limit is impossible, so this is constant low.
  assign timeout_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state, Avalon command and client-side bookkeeping.
  always_comb begin
    state_next       = state_reg;
    rd_addr_next     = rd_addr_reg;
    pending_next     = pending_reg;
    drain_next       = drain_reg;
    data_next        = data_reg;
    valid_next       = 1'b0;
    err_next         = err_reg;
    write_cmd        = 1'b0;
    read_cmd         = (state_reg == READ_REQ);

    // Writes older than a pending read go out first; younger ones wait.
    if (state_reg == IDLE || state_reg == WRITE) begin
      write_cmd = !fifo_empty && ((drain_reg != '0) || !pending_reg);
    end

    fifo_pop  = write_cmd && !avm_waitrequest;
    fifo_push = sdram_write_en && (!fifo_full || fifo_pop);
    read_ok   = sdram_read_en && !sdram_write_en && !pending_reg;

    if ((sdram_write_en && !fifo_push) || (sdram_read_en && !read_ok)) begin
      err_next = 1'b1;
    end

    fifo_count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    // Snapshot excludes an entry leaving on this very edge.
    if (read_ok) begin
      pending_next = 1'b1;
      rd_addr_next = address_sdram;
      drain_next   = fifo_count - CW'(fifo_pop);
    end else if (fifo_pop && (drain_reg != '0)) begin
      drain_next = drain_reg - CW'(1);
    end

    case (state_reg)
      IDLE, WRITE: begin
        if (pending_next && (drain_next == '0)) begin
          state_next = READ_REQ;
        end else if (fifo_count_after != '0) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      READ_REQ: begin
        if (!avm_waitrequest) begin
          state_next = READ_RESP;
        end
      end
      READ_RESP: begin
        if (avm_readdatavalid) begin
          data_next    = avm_readdata;
          valid_next   = 1'b1;
          pending_next = 1'b0;
          state_next   = (fifo_count_after != '0) ? WRITE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (timeout_fire) begin
      data_next    = TIMEOUT_DATA;
      valid_next   = 1'b1;
      err_next     = 1'b1;
      pending_next = 1'b0;
      state_next   = (fifo_count_after != '0) ? WRITE : IDLE;
    end
  end

  // State and client-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
      pending_reg <= 1'b0;
      drain_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
      pending_reg <= pending_next;
      drain_reg   <= drain_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  assign avm_read       = read_cmd;
  assign avm_write      = write_cmd;
  assign avm_address    = read_cmd  ? word_to_byte(rd_addr_reg) :
                          write_cmd ? word_to_byte(fifo_rdata[WR_ENTRY_W-1 -: WORD_ADDR_W]) : '0;
  assign avm_writedata  = write_cmd ? fifo_rdata[DATA_W-1:0] : '0;
  assign avm_byteenable = BYTE_EN_ALL;

  assign data_sdram          = data_reg;
  assign sdram_datareadvalid = valid_reg;
  assign wr_full             = fifo_full;
  assign protocol_err        = err_reg;
  assign bridge_idle         = fifo_empty && !pending_reg &&
                               (state_reg != READ_REQ) && (state_reg != READ_RESP);

endmodule

// File: tb/tb_sdram_access_bridge.sv
// Directed bench for sdram_access_bridge: one task per scenario.
module tb_sdram_access_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        wr_full;
  logic        bridge_idle;
  logic        protocol_err;
  logic [27:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  typedef struct packed {
    logic        is_read;
    logic [27:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t log_q[$];
  int   rd_cnt       = 0;
  int   valid_cnt    = 0;
  bit   overlap_seen = 1'b0;
  int   check_cnt    = 0;
  int   pass_cnt     = 0;

  sdram_access_bridge #(
    .WR_FIFO_DEPTH  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sdram_read_en       (sdram_read_en),
    .sdram_write_en      (sdram_write_en),
    .address_sdram       (address_sdram),
    .writeData_sdram     (writeData_sdram),
    .data_sdram          (data_sdram),
    .sdram_datareadvalid (sdram_datareadvalid),
    .wr_full             (wr_full),
    .bridge_idle         (bridge_idle),
    .protocol_err        (protocol_err),
    .avm_address         (avm_address),
    .avm_read            (avm_read),
    .avm_write           (avm_write),
    .avm_writedata       (avm_writedata),
    .avm_byteenable      (avm_byteenable),
    .avm_waitrequest     (avm_waitrequest),
    .avm_readdata        (avm_readdata),
    .avm_readdatavalid   (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // Avalon-side monitor: records accepted commands and read-return pulses.
  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) begin
      log_q.push_back({1'b0, avm_address, avm_writedata});
      $display("txn avm_write addr=%h data=%h", avm_address, avm_writedata);
    end
    if (avm_read && !avm_waitrequest) begin
      log_q.push_back({1'b1, avm_address, 32'h0});
      rd_cnt++;
      $display("txn avm_read  addr=%h", avm_address);
    end
    if (sdram_datareadvalid) begin
      valid_cnt++;
      $display("txn read_return data=%h", data_sdram);
    end
    if (avm_read && avm_write) overlap_seen = 1'b1;
  end

  task automatic do_reset();
    rst               = 1'b1;
    sdram_read_en     = 1'b0;
    sdram_write_en    = 1'b0;
    address_sdram     = '0;
    writeData_sdram   = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    rd_cnt    = 0;
    valid_cnt = 0;
  endtask

  // Waits (bounded) for the bridge's read to be accepted, then returns d.
  task automatic respond_read(input logic [31:0] d, input string name);
    int start = rd_cnt;
    bit got   = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (rd_cnt != start) got = 1'b1;
    end
    check_cnt++;
    if (!got) $display("FAIL %s_read_issue: got no avm_read in 30 cycles, required one", name);
    else pass_cnt++;
    if (got) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if ({data_sdram, sdram_datareadvalid, wr_full, protocol_err, avm_read, avm_write} !== 37'h0)
      $display("FAIL reset_outputs: got data=%h v=%b full=%b err=%b rd=%b wr=%b, required all 0",
               data_sdram, sdram_datareadvalid, wr_full, protocol_err, avm_read, avm_write);
    else pass_cnt++;
    check_cnt++;
    if (bridge_idle !== 1'b1) $display("FAIL reset_idle: got %b required 1", bridge_idle);
    else pass_cnt++;
    check_cnt++;
    if ({avm_address, avm_writedata, avm_byteenable} !== {28'h0, 32'h0, 4'hF})
      $display("FAIL reset_avm_bus: got addr=%h wd=%h be=%h required 0/0/F",
               avm_address, avm_writedata, avm_byteenable);
    else pass_cnt++;
  endtask

  task automatic test_read_basic();
    do_reset();
    @(posedge clk); #1;
    sdram_read_en = 1'b1; address_sdram = 26'h10;
    @(posedge clk); #1;
    sdram_read_en = 1'b0;
    check_cnt++;
    if ({avm_read, avm_write, avm_address} !== {1'b1, 1'b0, 28'h40})
      $display("FAIL rd_basic_cmd: got rd=%b wr=%b addr=%h required 1/0/40", avm_read, avm_write, avm_address);
    else pass_cnt++;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h0011_2233;
    check_cnt++;
    if (avm_read !== 1'b0) $display("FAIL rd_basic_read_drop: got %b required 0", avm_read);
    else pass_cnt++;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    check_cnt++;
    if ({sdram_datareadvalid, data_sdram} !== {1'b1, 32'h0011_2233})
      $display("FAIL rd_basic_return: got v=%b data=%h required 1/00112233", sdram_datareadvalid, data_sdram);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({valid_cnt, data_sdram, bridge_idle, protocol_err} !== {32'd1, 32'h0011_2233, 1'b1, 1'b0})
      $display("FAIL rd_basic_after: got pulses=%0d data=%h idle=%b err=%b required 1/00112233/1/0",
               valid_cnt, data_sdram, bridge_idle, protocol_err);
    else pass_cnt++;
  endtask

  task automatic test_write_order();
    txn_t exp_q[5];
    txn_t got;
    exp_q[0] = {1'b0, 28'h0, 32'hA000_0000};
    exp_q[1] = {1'b0, 28'h4, 32'hA000_0001};
    exp_q[2] = {1'b0, 28'h8, 32'hA000_0002};
    exp_q[3] = {1'b1, 28'h4, 32'h0};
    exp_q[4] = {1'b0, 28'hC, 32'hA000_0003};
    do_reset();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sdram_write_en = 1'b1; address_sdram = 26'(i); writeData_sdram = 32'hA000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    sdram_write_en = 1'b0; sdram_read_en = 1'b1; address_sdram = 26'h1;
    @(posedge clk); #1;
    sdram_read_en = 1'b0; sdram_write_en = 1'b1; address_sdram = 26'h3; writeData_sdram = 32'hA000_0003;
    @(posedge clk); #1;
    sdram_write_en = 1'b0;
    check_cnt++;
    if ({wr_full, protocol_err} !== 2'b10)
      $display("FAIL order_full_4: got full=%b err=%b required 1/0", wr_full, protocol_err);
    else pass_cnt++;
    avm_waitrequest = 1'b0;
    respond_read(32'h1111_0001, "order");
    repeat (6) @(posedge clk);
    #1;
    check_cnt++;
    if (log_q.size() != 5) $display("FAIL order_count: got %0d txns required 5", log_q.size());
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      got = (k < log_q.size()) ? log_q[k] : '1;
      check_cnt++;
      if (got !== exp_q[k]) $display("FAIL order_txn%0d: got %h required %h", k, got, exp_q[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if ({valid_cnt, data_sdram, bridge_idle} !== {32'd1, 32'h1111_0001, 1'b1})
      $display("FAIL order_return: got pulses=%0d data=%h idle=%b required 1/11110001/1",
               valid_cnt, data_sdram, bridge_idle);
    else pass_cnt++;
  endtask

  task automatic test_waitrequest();
    do_reset();
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    sdram_write_en = 1'b1; address_sdram = 26'h5; writeData_sdram = 32'h55;
    @(posedge clk); #1;
    sdram_write_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_cnt++;
      if ({avm_write, avm_address, avm_writedata} !== {1'b1, 28'h14, 32'h55})
        $display("FAIL stall_hold%0d: got wr=%b addr=%h data=%h required 1/14/55",
                 i, avm_write, avm_address, avm_writedata);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_cnt++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 28'h14, 32'h55})
      $display("FAIL stall_single: got %0d txns required exactly one write 14/55", log_q.size());
    else pass_cnt++;
    check_cnt++;
    if ({avm_write, bridge_idle} !== 2'b01)
      $display("FAIL stall_done: got wr=%b idle=%b required 0/1", avm_write, bridge_idle);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [27:0] exp_a [5];
    exp_a[0] = 28'h20; exp_a[1] = 28'h24; exp_a[2] = 28'h28; exp_a[3] = 28'h2C; exp_a[4] = 28'h34;
    do_reset();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sdram_write_en = 1'b1; address_sdram = 26'(8 + i); writeData_sdram = 32'hF0 + 32'(8 + i);
      if (i == 3) begin
        check_cnt++;
        if (wr_full !== 1'b0) $display("FAIL fill_full_at3: got %b required 0", wr_full);
        else pass_cnt++;
      end
    end
    @(posedge clk); #1;
    check_cnt++;
    if ({wr_full, protocol_err} !== 2'b10)
      $display("FAIL fill_full_at4: got full=%b err=%b required 1/0", wr_full, protocol_err);
    else pass_cnt++;
    address_sdram = 26'd12; writeData_sdram = 32'hF0 + 32'd12;
    @(posedge clk); #1;
    check_cnt++;
    if ({wr_full, protocol_err} !== 2'b11)
      $display("FAIL fill_overflow: got full=%b err=%b required 1/1", wr_full, protocol_err);
    else pass_cnt++;
    avm_waitrequest = 1'b0;
    address_sdram = 26'd13; writeData_sdram = 32'hF0 + 32'd13;
    @(posedge clk); #1;
    sdram_write_en = 1'b0;
    check_cnt++;
    if (wr_full !== 1'b1) $display("FAIL fill_push_pop_full: got %b required 1", wr_full);
    else pass_cnt++;
    repeat (8) @(posedge clk);
    #1;
    check_cnt++;
    if (log_q.size() != 5) $display("FAIL fill_count: got %0d writes required 5", log_q.size());
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      check_cnt++;
      if (k >= log_q.size() || log_q[k].addr !== exp_a[k])
        $display("FAIL fill_addr%0d: got %h required %h", k,
                 (k < log_q.size()) ? log_q[k].addr : 28'hFFFFFFF, exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    @(posedge clk); #1;
    sdram_read_en = 1'b1; address_sdram = 26'h20;
    @(posedge clk); #1;
    sdram_read_en = 1'b0;
    check_cnt++;
    if (avm_read !== 1'b1) $display("FAIL rstmid_read_up: got %b required 1", avm_read);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h99;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({valid_cnt, data_sdram, bridge_idle, protocol_err, avm_read} !== {32'd0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL rstmid_read: got pulses=%0d data=%h idle=%b err=%b rd=%b required 0/0/1/0/0",
               valid_cnt, data_sdram, bridge_idle, protocol_err, avm_read);
    else pass_cnt++;
    avm_waitrequest = 1'b1;
    sdram_write_en = 1'b1; address_sdram = 26'h50; writeData_sdram = 32'h5A;
    @(posedge clk); #1;
    sdram_write_en = 1'b0;
    check_cnt++;
    if (avm_write !== 1'b1) $display("FAIL rstmid_write_up: got %b required 1", avm_write);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_cnt++;
    if ({avm_write, bridge_idle} !== 2'b01)
      $display("FAIL rstmid_write_drop: got wr=%b idle=%b required 0/1", avm_write, bridge_idle);
    else pass_cnt++;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if (log_q.size() != 1) $display("FAIL rstmid_lost_write: got %0d txns required 1 (the read)", log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    sdram_read_en = 1'b1; address_sdram = 26'h40;
    @(posedge clk); #1;
    address_sdram = 26'h41;
    @(posedge clk); #1;
    sdram_read_en = 1'b0;
    check_cnt++;
    if (protocol_err !== 1'b1) $display("FAIL perr_double_read: got %b required 1", protocol_err);
    else pass_cnt++;
    avm_waitrequest = 1'b0;
    respond_read(32'hCAFE_0040, "perr");
    repeat (4) @(posedge clk);
    #1;
    check_cnt++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 28'h100, 32'h0} || data_sdram !== 32'hCAFE_0040)
      $display("FAIL perr_single_read: got %0d txns data=%h required one read of 100 data cafe0040",
               log_q.size(), data_sdram);
    else pass_cnt++;

    do_reset();
    @(posedge clk); #1;
    sdram_read_en = 1'b1; sdram_write_en = 1'b1; address_sdram = 26'h30; writeData_sdram = 32'h77;
    @(posedge clk); #1;
    sdram_read_en = 1'b0; sdram_write_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_cnt++;
    if (protocol_err !== 1'b1) $display("FAIL perr_rw_same: got %b required 1", protocol_err);
    else pass_cnt++;
    check_cnt++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 28'hC0, 32'h77} || valid_cnt != 0)
      $display("FAIL perr_rw_result: got %0d txns pulses=%0d required one write C0/77 no pulse",
               log_q.size(), valid_cnt);
    else pass_cnt++;
  endtask

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int n    = 0;
    bit seen = 1'b0;
    do_reset();
    @(posedge clk); #1;
    sdram_read_en = 1'b1; address_sdram = 26'h7;
    @(posedge clk); #1;
    sdram_read_en = 1'b0;
    n = 1;
    while (!seen && n < 40) begin
      if (sdram_datareadvalid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_cnt++;
    if (!seen || n < 16 || n > 18)
      $display("FAIL tmo_pulse: got seen=%b at cycle %0d required pulse at cycle 16..18", seen, n);
    else pass_cnt++;
    check_cnt++;
    if ({data_sdram, protocol_err} !== {32'hDEAD_BEEF, 1'b1})
      $display("FAIL tmo_data: got data=%h err=%b required deadbeef/1", data_sdram, protocol_err);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({sdram_datareadvalid, bridge_idle} !== 2'b01)
      $display("FAIL tmo_after: got v=%b idle=%b required 0/1", sdram_datareadvalid, bridge_idle);
    else pass_cnt++;
  endtask
`endif

  task automatic test_exclusive();
    check_cnt++;
    if (overlap_seen !== 1'b0) $display("FAIL cmd_exclusive: got read+write overlap required none");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_order();
    test_waitrequest();
    test_fill();
    test_reset_mid_transfer();
    test_protocol_err();
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
